// File: rtl/vtx_pkg.sv
// Shared state encodings, slot types and helpers for the vtx transaction tracker.
package vtx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  localparam logic [2:0] RES_OK      = 3'd0;
  localparam logic [2:0] RES_ILLEGAL = 3'd1;
  localparam logic [2:0] RES_MEM_ERR = 3'd2;

  localparam int BEN_W = 8;

  // Per-slot control bits; address/data payloads live in parameter-sized arrays.
  typedef struct packed {
    logic             cen;
    logic             wen;
    logic             error;
    logic [BEN_W-1:0] ben;
  } vtx_slot_flags_t;

  function automatic int txn_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vtx_txn_slots.sv
// Memory transaction slot array: captures accepted requests in order, tracks
// overflow and completes reads with the data returned one cycle later.
module vtx_txn_slots
  import vtx_pkg::*;
#(
  parameter int NUM_TXN = 4,
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int CW      = txn_cnt_w(NUM_TXN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      cap_en,
  input  logic                      mem_cen,
  input  logic                      mem_wen,
  input  logic                      mem_stall,
  input  logic [AW-1:0]             mem_addr,
  input  logic [XLEN-1:0]           mem_wdata,
  input  logic [BEN_W-1:0]          mem_ben,
  input  logic [XLEN-1:0]           mem_rdata,
  input  logic                      mem_error,
  output logic [NUM_TXN-1:0]        slot_cen,
  output logic [NUM_TXN-1:0]        slot_wen,
  output logic [NUM_TXN-1:0]        slot_error,
  output logic [NUM_TXN*AW-1:0]     slot_addr,
  output logic [NUM_TXN*XLEN-1:0]   slot_wdata,
  output logic [NUM_TXN*XLEN-1:0]   slot_rdata,
  output logic [NUM_TXN*BEN_W-1:0]  slot_ben,
  output logic [CW-1:0]             count,
  output logic                      ovf,
  output logic                      rd_pending
);

  localparam int IW = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;

  vtx_slot_flags_t [NUM_TXN-1:0]          flg_q, flg_d;
  logic [NUM_TXN-1:0][AW-1:0]             addr_q, addr_d;
  logic [NUM_TXN-1:0][XLEN-1:0]           wdata_q, wdata_d;
  logic [NUM_TXN-1:0][XLEN-1:0]           rdata_q, rdata_d;
  logic [CW-1:0]                          cnt_q, cnt_d;
  logic                                   ovf_q, ovf_d;
  logic                                   pend_q, pend_d;
  logic [IW-1:0]                          pidx_q, pidx_d;
  logic [IW-1:0]                          idx;
  logic                                   accept;

  always_comb begin
    flg_d   = flg_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    pidx_d  = pidx_q;
    idx     = cnt_q[IW-1:0];
    accept  = cap_en & mem_cen & ~mem_stall;

    // Read data returns exactly one cycle after acceptance, whatever the FSM state.
    if (pend_q) begin
      rdata_d[pidx_q]     = mem_rdata;
      flg_d[pidx_q].error = mem_error;
      pend_d              = 1'b0;
    end

    if (clear) begin
      flg_d   = '0;
      addr_d  = '0;
      wdata_d = '0;
      rdata_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      pend_d  = 1'b0;
      pidx_d  = '0;
    end else if (accept) begin
      if (cnt_q == CW'(NUM_TXN)) begin
        ovf_d = 1'b1;
      end else begin
        flg_d[idx].cen = 1'b1;
        flg_d[idx].wen = mem_wen;
        flg_d[idx].ben = mem_ben;
        addr_d[idx]    = mem_addr;
        wdata_d[idx]   = mem_wdata;
        cnt_d          = cnt_q + CW'(1);
        if (!mem_wen) begin
          pend_d = 1'b1;
          pidx_d = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flg_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      pidx_q  <= '0;
    end else begin
      flg_q   <= flg_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
    end
  end

  for (genvar g = 0; g < NUM_TXN; g++) begin : g_out
    assign slot_cen[g]                = flg_q[g].cen;
    assign slot_wen[g]                = flg_q[g].wen;
    assign slot_error[g]              = flg_q[g].error;
    assign slot_ben[g*BEN_W +: BEN_W] = flg_q[g].ben;
  end

  assign slot_addr  = addr_q;
  assign slot_wdata = wdata_q;
  assign slot_rdata = rdata_q;
  assign count      = cnt_q;
  assign ovf        = ovf_q;
  assign rd_pending = pend_q;

endmodule

// File: rtl/vtx_txn_tracker.sv
// Collects one retired CPU->COP instruction (issue, response, memory traffic,
// register snapshots) into a registered record announced by a vtx_valid pulse.
module vtx_txn_tracker
  import vtx_pkg::*;
#(
  parameter int NUM_TXN = 4,
  parameter int NUM_CPR = 16,
  parameter int XLEN    = 32,
  parameter int AW      = 32
) (
  input  logic                              vtx_clk,
  input  logic                              vtx_reset,
  input  logic                              vtx_cpu_req,
  input  logic                              vtx_cpu_ack,
  input  logic                              vtx_cop_rsp,
  input  logic                              vtx_cop_ack,
  input  logic [31:0]                       vtx_instr_enc,
  input  logic [XLEN-1:0]                   vtx_instr_rs1,
  input  logic [XLEN-1:0]                   vtx_instr_rs2,
  input  logic [2:0]                        vtx_rsp_result,
  input  logic [XLEN-1:0]                   vtx_rsp_wdata,
  input  logic [4:0]                        vtx_rsp_waddr,
  input  logic                              vtx_rsp_wen,
  input  logic                              mem_cen,
  input  logic                              mem_wen,
  input  logic                              mem_stall,
  input  logic [AW-1:0]                     mem_addr,
  input  logic [XLEN-1:0]                   mem_wdata,
  input  logic [BEN_W-1:0]                  mem_ben,
  input  logic [XLEN-1:0]                   mem_rdata,
  input  logic                              mem_error,
  input  logic [NUM_CPR*XLEN-1:0]           cprs_live,
  output logic                              vtx_valid,
  output logic [31:0]                       vtx_rec_enc,
  output logic [XLEN-1:0]                   vtx_rec_rs1,
  output logic [XLEN-1:0]                   vtx_rec_rs2,
  output logic [2:0]                        vtx_rec_result,
  output logic [XLEN-1:0]                   vtx_rec_wdata,
  output logic [4:0]                        vtx_rec_waddr,
  output logic                              vtx_rec_wen,
  output logic [NUM_TXN-1:0]                vtx_mem_cen,
  output logic [NUM_TXN-1:0]                vtx_mem_wen,
  output logic [NUM_TXN-1:0]                vtx_mem_error,
  output logic [NUM_TXN*AW-1:0]             vtx_mem_addr,
  output logic [NUM_TXN*XLEN-1:0]           vtx_mem_wdata,
  output logic [NUM_TXN*XLEN-1:0]           vtx_mem_rdata,
  output logic [NUM_TXN*BEN_W-1:0]          vtx_mem_ben,
  output logic [txn_cnt_w(NUM_TXN)-1:0]     vtx_txn_count,
  output logic                              vtx_txn_ovf,
  output logic [NUM_CPR*XLEN-1:0]           vtx_cprs_pre,
  output logic [NUM_CPR*XLEN-1:0]           vtx_cprs_post
);

  localparam int CPRW = NUM_CPR * XLEN;

  logic [1:0]      state_q, state_d;
  logic            valid_q, valid_d;
  logic [31:0]     enc_q, enc_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [2:0]      result_q, result_d;
  logic [XLEN-1:0] rwdata_q, rwdata_d;
  logic [4:0]      waddr_q, waddr_d;
  logic            rwen_q, rwen_d;
  logic [CPRW-1:0] pre_q, pre_d;
  logic [CPRW-1:0] post_q, post_d;
  logic            issue;
  logic            rsp_hs;
  logic            rd_pend;

  always_comb begin
    // Issue is only honoured where a new record may start; elsewhere it is a protocol error.
    issue    = vtx_cpu_req & vtx_cpu_ack & ((state_q == ST_IDLE) | (state_q == ST_EMIT));
    rsp_hs   = vtx_cop_rsp & vtx_cop_ack & (state_q == ST_BUSY);
    state_d  = state_q;
    valid_d  = 1'b0;
    enc_d    = enc_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    result_d = result_q;
    rwdata_d = rwdata_q;
    waddr_d  = waddr_q;
    rwen_d   = rwen_q;
    pre_d    = pre_q;
    post_d   = post_q;

    case (state_q)
      ST_IDLE: if (issue) state_d = ST_BUSY;
      ST_BUSY: if (rsp_hs) state_d = ST_WB;
      ST_WB: begin
        // The register file has committed by the end of the first WB cycle;
        // an outstanding read keeps us here until its data is in the slot.
        if (!rd_pend) begin
          state_d = ST_EMIT;
          valid_d = 1'b1;
          post_d  = cprs_live;
        end
      end
      ST_EMIT: state_d = issue ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      enc_d = vtx_instr_enc;
      rs1_d = vtx_instr_rs1;
      rs2_d = vtx_instr_rs2;
      pre_d = cprs_live;
    end

    if (rsp_hs) begin
      result_d = vtx_rsp_result;
      rwdata_d = vtx_rsp_wdata;
      waddr_d  = vtx_rsp_waddr;
      rwen_d   = vtx_rsp_wen;
    end
  end

  always_ff @(posedge vtx_clk) begin
    if (vtx_reset) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      enc_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      rwdata_q <= '0;
      waddr_q  <= '0;
      rwen_q   <= 1'b0;
      pre_q    <= '0;
      post_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      enc_q    <= enc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      result_q <= result_d;
      rwdata_q <= rwdata_d;
      waddr_q  <= waddr_d;
      rwen_q   <= rwen_d;
      pre_q    <= pre_d;
      post_q   <= post_d;
    end
  end

  vtx_txn_slots #(
    .NUM_TXN (NUM_TXN),
    .XLEN    (XLEN),
    .AW      (AW)
  ) u_slots (
    .clk        (vtx_clk),
    .rst        (vtx_reset),
    .clear      (issue),
    .cap_en     (state_q == ST_BUSY),
    .mem_cen    (mem_cen),
    .mem_wen    (mem_wen),
    .mem_stall  (mem_stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ben    (mem_ben),
    .mem_rdata  (mem_rdata),
    .mem_error  (mem_error),
    .slot_cen   (vtx_mem_cen),
    .slot_wen   (vtx_mem_wen),
    .slot_error (vtx_mem_error),
    .slot_addr  (vtx_mem_addr),
    .slot_wdata (vtx_mem_wdata),
    .slot_rdata (vtx_mem_rdata),
    .slot_ben   (vtx_mem_ben),
    .count      (vtx_txn_count),
    .ovf        (vtx_txn_ovf),
    .rd_pending (rd_pend)
  );

  assign vtx_valid      = valid_q;
  assign vtx_rec_enc    = enc_q;
  assign vtx_rec_rs1    = rs1_q;
  assign vtx_rec_rs2    = rs2_q;
  assign vtx_rec_result = result_q;
  assign vtx_rec_wdata  = rwdata_q;
  assign vtx_rec_waddr  = waddr_q;
  assign vtx_rec_wen    = rwen_q;
  assign vtx_cprs_pre   = pre_q;
  assign vtx_cprs_post  = post_q;

endmodule

// File: tb/tb_vtx_txn_tracker.sv
// Directed-plus-random bench for vtx_txn_tracker with a transaction-level record model.
module tb_vtx_txn_tracker;

  localparam int NUM_TXN = 4;
  localparam int NUM_CPR = 16;
  localparam int XLEN    = 32;
  localparam int AW      = 32;
  localparam int CW      = 3;
  localparam int CPRW    = NUM_CPR * XLEN;

  logic                      vtx_clk = 1'b0;
  logic                      vtx_reset = 1'b1;
  logic                      vtx_cpu_req = 1'b0, vtx_cpu_ack = 1'b0;
  logic                      vtx_cop_rsp = 1'b0, vtx_cop_ack = 1'b0;
  logic [31:0]               vtx_instr_enc = '0;
  logic [XLEN-1:0]           vtx_instr_rs1 = '0, vtx_instr_rs2 = '0;
  logic [2:0]                vtx_rsp_result = '0;
  logic [XLEN-1:0]           vtx_rsp_wdata = '0;
  logic [4:0]                vtx_rsp_waddr = '0;
  logic                      vtx_rsp_wen = 1'b0;
  logic                      mem_cen = 1'b0, mem_wen = 1'b0, mem_stall = 1'b0;
  logic [AW-1:0]             mem_addr = '0;
  logic [XLEN-1:0]           mem_wdata = '0, mem_rdata = '0;
  logic [7:0]                mem_ben = '0;
  logic                      mem_error = 1'b0;
  logic [CPRW-1:0]           cprs_live = '0;

  logic                      vtx_valid;
  logic [31:0]               vtx_rec_enc;
  logic [XLEN-1:0]           vtx_rec_rs1, vtx_rec_rs2, vtx_rec_wdata;
  logic [2:0]                vtx_rec_result;
  logic [4:0]                vtx_rec_waddr;
  logic                      vtx_rec_wen;
  logic [NUM_TXN-1:0]        vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
  logic [NUM_TXN*AW-1:0]     vtx_mem_addr;
  logic [NUM_TXN*XLEN-1:0]   vtx_mem_wdata, vtx_mem_rdata;
  logic [NUM_TXN*8-1:0]      vtx_mem_ben;
  logic [CW-1:0]             vtx_txn_count;
  logic                      vtx_txn_ovf;
  logic [CPRW-1:0]           vtx_cprs_pre, vtx_cprs_post;

  vtx_txn_tracker #(.NUM_TXN(NUM_TXN), .NUM_CPR(NUM_CPR), .XLEN(XLEN), .AW(AW)) dut (
    .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
    .vtx_cpu_req(vtx_cpu_req), .vtx_cpu_ack(vtx_cpu_ack),
    .vtx_cop_rsp(vtx_cop_rsp), .vtx_cop_ack(vtx_cop_ack),
    .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1), .vtx_instr_rs2(vtx_instr_rs2),
    .vtx_rsp_result(vtx_rsp_result), .vtx_rsp_wdata(vtx_rsp_wdata),
    .vtx_rsp_waddr(vtx_rsp_waddr), .vtx_rsp_wen(vtx_rsp_wen),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_stall(mem_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
    .mem_rdata(mem_rdata), .mem_error(mem_error),
    .cprs_live(cprs_live),
    .vtx_valid(vtx_valid),
    .vtx_rec_enc(vtx_rec_enc), .vtx_rec_rs1(vtx_rec_rs1), .vtx_rec_rs2(vtx_rec_rs2),
    .vtx_rec_result(vtx_rec_result), .vtx_rec_wdata(vtx_rec_wdata),
    .vtx_rec_waddr(vtx_rec_waddr), .vtx_rec_wen(vtx_rec_wen),
    .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen), .vtx_mem_error(vtx_mem_error),
    .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata),
    .vtx_mem_rdata(vtx_mem_rdata), .vtx_mem_ben(vtx_mem_ben),
    .vtx_txn_count(vtx_txn_count), .vtx_txn_ovf(vtx_txn_ovf),
    .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post)
  );

  always #5 vtx_clk = ~vtx_clk;

  int n_chk = 0;
  int n_err = 0;

  // Expected record, built from the requests the bench chooses to have accepted.
  logic [AW-1:0]   e_addr  [NUM_TXN];
  logic [XLEN-1:0] e_wdata [NUM_TXN];
  logic [XLEN-1:0] e_rdata [NUM_TXN];
  logic [7:0]      e_ben   [NUM_TXN];
  logic            e_cen   [NUM_TXN];
  logic            e_wen   [NUM_TXN];
  logic            e_err   [NUM_TXN];
  int              e_cnt;
  logic            e_ovf;
  logic [31:0]     e_enc;
  logic [XLEN-1:0] e_rs1, e_rs2, e_rwdata;
  logic [2:0]      e_result;
  logic [4:0]      e_waddr;
  logic            e_rwen;
  logic [CPRW-1:0] e_pre, e_post, last_live;
  int              m_pend = -1;
  int              new_pend = -1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_live();
    for (int i = 0; i < NUM_CPR; i++) cprs_live[i*XLEN +: XLEN] = $urandom;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_TXN; i++) begin
      e_addr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0; e_ben[i] = '0;
      e_cen[i] = 1'b0; e_wen[i] = 1'b0; e_err[i] = 1'b0;
    end
    e_cnt = 0;
    e_ovf = 1'b0;
  endtask

  // One clock: random read-return bus, pending read booked into the model, fresh register file.
  task automatic tick();
    mem_rdata = $urandom;
    mem_error = 1'($urandom_range(0, 1));
    if (m_pend >= 0) begin
      e_rdata[m_pend] = mem_rdata;
      e_err[m_pend]   = mem_error;
    end
    m_pend    = new_pend;
    new_pend  = -1;
    last_live = cprs_live;
    @(posedge vtx_clk);
    #1;
    rand_live();
  endtask

  task automatic check_record(input logic exp_vld);
    logic [NUM_TXN-1:0]      x_cen, x_wen, x_err;
    logic [NUM_TXN*AW-1:0]   x_addr;
    logic [NUM_TXN*XLEN-1:0] x_wd, x_rd;
    logic [NUM_TXN*8-1:0]    x_ben;
    for (int i = 0; i < NUM_TXN; i++) begin
      x_cen[i] = e_cen[i]; x_wen[i] = e_wen[i]; x_err[i] = e_err[i];
      x_addr[i*AW +: AW]   = e_addr[i];
      x_wd[i*XLEN +: XLEN] = e_wdata[i];
      x_rd[i*XLEN +: XLEN] = e_rdata[i];
      x_ben[i*8 +: 8]      = e_ben[i];
    end
    chk("valid",     512'(vtx_valid),      512'(exp_vld));
    chk("enc",       512'(vtx_rec_enc),    512'(e_enc));
    chk("rs1",       512'(vtx_rec_rs1),    512'(e_rs1));
    chk("rs2",       512'(vtx_rec_rs2),    512'(e_rs2));
    chk("result",    512'(vtx_rec_result), 512'(e_result));
    chk("rsp_wdata", 512'(vtx_rec_wdata),  512'(e_rwdata));
    chk("rsp_waddr", 512'(vtx_rec_waddr),  512'(e_waddr));
    chk("rsp_wen",   512'(vtx_rec_wen),    512'(e_rwen));
    chk("txn_count", 512'(vtx_txn_count),  512'(e_cnt));
    chk("txn_ovf",   512'(vtx_txn_ovf),    512'(e_ovf));
    chk("mem_cen",   512'(vtx_mem_cen),    512'(x_cen));
    chk("mem_wen",   512'(vtx_mem_wen),    512'(x_wen));
    chk("mem_error", 512'(vtx_mem_error),  512'(x_err));
    chk("mem_addr",  512'(vtx_mem_addr),   512'(x_addr));
    chk("mem_wdata", 512'(vtx_mem_wdata),  512'(x_wd));
    chk("mem_rdata", 512'(vtx_mem_rdata),  512'(x_rd));
    chk("mem_ben",   512'(vtx_mem_ben),    512'(x_ben));
    chk("cprs_pre",  vtx_cprs_pre,         e_pre);
    chk("cprs_post", vtx_cprs_post,        e_post);
  endtask

  task automatic zero_model();
    clear_model();
    e_enc = '0; e_rs1 = '0; e_rs2 = '0; e_result = '0;
    e_rwdata = '0; e_waddr = '0; e_rwen = 1'b0; e_pre = '0; e_post = '0;
    m_pend = -1; new_pend = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      vtx_cpu_req = 1'($urandom); vtx_cpu_ack = 1'b0;
      vtx_cop_rsp = 1'($urandom); vtx_cop_ack = 1'($urandom);
      mem_cen = 1'($urandom); mem_stall = 1'b0; mem_wen = 1'b0; mem_addr = $urandom;
      tick();
      chk("idle_valid", 512'(vtx_valid), 512'(1'b0));
      chk("idle_hold_enc", 512'(vtx_rec_enc), 512'(e_enc));
      chk("idle_hold_count", 512'(vtx_txn_count), 512'(e_cnt));
    end
    vtx_cpu_req = 1'b0; vtx_cop_rsp = 1'b0; vtx_cop_ack = 1'b0; mem_cen = 1'b0;
  endtask

  task automatic issue(input logic [31:0] enc, input logic [XLEN-1:0] rs1);
    vtx_cpu_req = 1'b1; vtx_cpu_ack = 1'b1;
    vtx_instr_enc = enc; vtx_instr_rs1 = rs1; vtx_instr_rs2 = $urandom;
    mem_cen = 1'($urandom); mem_stall = 1'b0; mem_wen = 1'b0; mem_addr = $urandom;
    clear_model();
    e_enc = enc; e_rs1 = rs1; e_rs2 = vtx_instr_rs2; e_pre = cprs_live;
    tick();
    vtx_cpu_req = 1'b0; vtx_cpu_ack = 1'b0; mem_cen = 1'b0;
  endtask

  task automatic drive_rsp(input logic [XLEN-1:0] rwd, input logic [4:0] rwa, input logic rwe);
    vtx_cop_rsp = 1'b1; vtx_cop_ack = 1'b1;
    vtx_rsp_result = 3'($urandom); vtx_rsp_wdata = rwd; vtx_rsp_waddr = rwa; vtx_rsp_wen = rwe;
    e_result = vtx_rsp_result; e_rwdata = rwd; e_waddr = rwa; e_rwen = rwe;
  endtask

  // wr_mode: 0 all reads, 1 all writes, 2 random. rsp_pend_in puts the response
  // in the same cycle as the last request (forced to be a read).
  task automatic do_instr(input logic [31:0] enc, input logic [XLEN-1:0] rs1, input int nreq,
                          input int wr_mode, input bit rsp_pend_in, input logic [AW-1:0] base,
                          input logic [XLEN-1:0] rwd, input logic [4:0] rwa, input logic rwe);
    bit rsp_pend, pend_at_rsp, w, last;
    rsp_pend    = rsp_pend_in && (nreq > 0);
    pend_at_rsp = 1'b0;
    issue(enc, rs1);
    chk("busy_valid", 512'(vtx_valid), 512'(1'b0));
    if ($urandom_range(0, 1) == 1) begin
      vtx_cop_rsp = 1'b1; vtx_cop_ack = 1'b0;
      tick();
      vtx_cop_rsp = 1'b0;
      chk("rsp_noack_valid", 512'(vtx_valid), 512'(1'b0));
    end
    for (int i = 0; i < nreq; i++) begin
      repeat ($urandom_range(0, 1)) begin
        mem_cen = 1'b1; mem_stall = 1'b1; mem_wen = 1'($urandom); mem_addr = $urandom;
        tick();
        chk("stall_valid", 512'(vtx_valid), 512'(1'b0));
      end
      last = (i == nreq - 1);
      w = (wr_mode == 2) ? 1'($urandom) : (wr_mode == 1);
      if (last && rsp_pend) w = 1'b0;
      mem_cen = 1'b1; mem_stall = 1'b0; mem_wen = w;
      mem_addr = base + AW'(4 * i); mem_wdata = $urandom; mem_ben = 8'($urandom);
      if (e_cnt < NUM_TXN) begin
        e_cen[e_cnt] = 1'b1; e_wen[e_cnt] = w; e_addr[e_cnt] = mem_addr;
        e_wdata[e_cnt] = mem_wdata; e_ben[e_cnt] = mem_ben;
        if (!w) new_pend = e_cnt;
        if (last && rsp_pend) pend_at_rsp = 1'b1;
        e_cnt++;
      end else begin
        e_ovf = 1'b1;
      end
      if (last && rsp_pend) drive_rsp(rwd, rwa, rwe);
      tick();
      mem_cen = 1'b0; vtx_cop_rsp = 1'b0; vtx_cop_ack = 1'b0;
      chk("busy_valid", 512'(vtx_valid), 512'(1'b0));
    end
    if (!rsp_pend) begin
      drive_rsp(rwd, rwa, rwe);
      mem_cen = 1'($urandom); mem_stall = 1'b1;
      tick();
      vtx_cop_rsp = 1'b0; vtx_cop_ack = 1'b0; mem_cen = 1'b0; mem_stall = 1'b0;
      chk("wb_valid", 512'(vtx_valid), 512'(1'b0));
    end
    mem_cen = 1'($urandom); mem_stall = 1'b0; mem_wen = 1'b0; mem_addr = $urandom;
    if (pend_at_rsp) begin
      tick();
      chk("wb_stretch_valid", 512'(vtx_valid), 512'(1'b0));
    end
    tick();
    mem_cen = 1'b0;
    e_post = last_live;
    check_record(1'b1);
  endtask

  initial begin
    rand_live();
    zero_model();
    repeat (2) @(posedge vtx_clk);
    #1;
    check_record(1'b0);
    vtx_reset = 1'b0;
    idle(2);

    // Plain op, no memory traffic
    do_instr(32'h0000_702B, 32'd5, 0, 2, 1'b0, '0, 32'hDEAD_BEEF, 5'd3, 1'b1);
    idle(2);
    // Two loads, response alongside the second read's data
    do_instr($urandom, $urandom, 2, 0, 1'b0, 32'h100, $urandom, 5'($urandom), 1'b1);
    idle(1);
    // Response with a read still outstanding
    do_instr($urandom, $urandom, 1, 0, 1'b1, $urandom, $urandom, 5'($urandom), 1'b0);
    idle(1);
    // Five stores overflow four slots; the next issue clears overflow
    do_instr($urandom, $urandom, 5, 1, 1'b0, 32'h200, $urandom, 5'($urandom), 1'b1);
    idle(1);
    do_instr($urandom, $urandom, 0, 2, 1'b0, '0, $urandom, 5'($urandom), 1'b1);
    idle(1);
    // Back-to-back: second issue lands in the EMIT cycle
    do_instr($urandom, $urandom, 2, 2, 1'b0, $urandom, $urandom, 5'($urandom), 1'b1);
    do_instr($urandom, $urandom, 1, 2, 1'b0, $urandom, $urandom, 5'($urandom), 1'b1);
    idle(1);

    // Reset in BUSY after one store
    issue($urandom, $urandom);
    mem_cen = 1'b1; mem_stall = 1'b0; mem_wen = 1'b1; mem_addr = $urandom; mem_wdata = $urandom;
    tick();
    mem_cen = 1'b0;
    vtx_reset = 1'b1;
    tick();
    vtx_reset = 1'b0;
    zero_model();
    check_record(1'b0);
    idle(3);
    do_instr($urandom, $urandom, 2, 2, 1'b0, $urandom, $urandom, 5'($urandom), 1'b1);
    idle(1);

    for (int k = 0; k < 24; k++) begin
      do_instr($urandom, $urandom, $urandom_range(0, 6), 2, 1'($urandom),
               $urandom, $urandom, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
